// File: rtl/super_pkg.sv
// Shared front-end types: the predecoded instruction record passed from fetch to decode.
package super_pkg;

    localparam int IrFifoDepth = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ptaken;
        logic [31:0] ptarget;
        logic [1:0]  errs;
    } ir_reg_t;

    localparam ir_reg_t NULL_IR_REG = '0;

endpackage

// File: rtl/ir_fifo.sv
// Dual-lane in-order instruction queue, fetch -> decode; 1-cycle latency, 0 when IR_FIFO_BYPASS_EN and empty.
// Fetch is stalled unless two entries are free; flush drops contents and same-cycle traffic.
import super_pkg::*;

module ir_fifo #(
    parameter int Depth = IrFifoDepth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [1:0]                   push_valid_i,
    input  logic [2*$bits(ir_reg_t)-1:0] push_data_i,
    output logic                         push_ready_o,
    output logic [1:0]                   pop_valid_o,
    output logic [2*$bits(ir_reg_t)-1:0] pop_data_o,
    input  logic [1:0]                   pop_ack_i,
    output logic [$clog2(Depth):0]       count_o
);

    localparam int W  = $bits(ir_reg_t);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    ir_reg_t       mem_q [Depth];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d, n_push, n_pop;
    ir_reg_t       in0, in1, out0, out1;
    logic          push_ready, acc0, acc1, byp, we0, we1;
    logic [1:0]    pop_vld, ack_eff;

    assign in0 = push_data_i[W-1:0];
    assign in1 = push_data_i[2*W-1:W];

    assign push_ready = count_q <= CW'(Depth - 2);
    assign acc0 = push_ready && push_valid_i[0] && !flush_i;
    // A predicted-taken lane0 redirects fetch, so lane1 is on the wrong path.
    assign acc1 = acc0 && push_valid_i[1] && !in0.ptaken;

`ifdef IR_FIFO_BYPASS_EN
    assign byp = (count_q == '0) && !flush_i;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        pop_vld = {count_q >= CW'(2), count_q != '0};
        out0    = mem_q[rptr_q];
        out1    = mem_q[rptr_q + PW'(1)];
`ifdef IR_FIFO_BYPASS_EN
        if (byp) begin
            pop_vld = {acc1, acc0};
            out0    = in0;
            out1    = in1;
        end
`endif
        if (!pop_vld[0]) out0 = NULL_IR_REG;
        if (!pop_vld[1]) out1 = NULL_IR_REG;
    end

    // Lane1 ack without lane0 is treated as no ack at all.
    assign ack_eff[0] = pop_ack_i[0] & pop_vld[0];
    assign ack_eff[1] = pop_ack_i[1] & pop_ack_i[0] & pop_vld[1];

    assign n_push = CW'(acc0) + CW'(acc1);
    assign n_pop  = CW'(ack_eff[0]) + CW'(ack_eff[1]);
    assign we0    = acc0 && !(byp && ack_eff[0]);
    assign we1    = acc1 && !(byp && ack_eff[1]);

    assign count_d = flush_i ? '0 : count_q + n_push - n_pop;
    assign wptr_d  = flush_i ? '0 : wptr_q + PW'(n_push);
    assign rptr_d  = flush_i ? '0 : rptr_q + PW'(n_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= NULL_IR_REG;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            if (we0) mem_q[wptr_q]          <= in0;
            if (we1) mem_q[wptr_q + PW'(1)] <= in1;
        end
    end

    assign push_ready_o = push_ready;
    assign pop_valid_o  = pop_vld;
    assign pop_data_o   = {out1, out0};
    assign count_o      = count_q;

`ifndef SYNTHESIS
    a_push_lanes: assert property (@(posedge clk_i) disable iff (!rst_ni) push_valid_i != 2'b10)
        else $error("ir_fifo: illegal push_valid_i=10");
    a_ack_lanes: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_ack_i != 2'b10)
        else $error("ir_fifo: illegal pop_ack_i=10");
    a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) (pop_ack_i & ~pop_vld) == 2'b00)
        else $error("ir_fifo: ack on invalid lane");
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CW'(Depth))
        else $error("ir_fifo: occupancy above depth");
`endif

endmodule

// File: doc/ir_fifo.md
Name: ir_fifo

Overview:
- Dual-lane instruction queue between fetch/predecode and the decoder.
- Fetch pushes up to two ir_reg_t entries per cycle; decode pops up to two in program order.
- Decouples fetch stalls from decode/issue stalls.
- Flushed on redirect: commit flush, mispredict or trap.

Parameters:
- Depth, 4: number of ir_reg_t entries; power of two, at least 2.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  reset; asynchronous, active-low
- flush_i  input  1  discard all entries and any push in the same cycle
- push_valid_i  input  2  lane valids from fetch; legal values 00, 01, 11
- push_data_i  input  2*$bits(ir_reg_t)  lane0 in the low half, lane1 in the high half
- push_ready_o  output  1  at least 2 free entries
- pop_valid_o  output  2  head entry valid [0]; head+1 entry valid [1]
- pop_data_o  output  2*$bits(ir_reg_t)  head in the low half, head+1 in the high half
- pop_ack_i  input  2  decoder consumes lanes; legal values 00, 01, 11; must be a subset of pop_valid_o
- count_o  output  $clog2(Depth)+1  current occupancy

Behaviour:
- Reset values:
  - count, read pointer and write pointer = 0.
  - Storage = NULL_IR_REG.
  - pop_valid_o = 00, pop_data_o = all zero, push_ready_o = 1, count_o = 0.
- Pointers are $clog2(Depth) bits and wrap modulo Depth.
- Push handshake:
  - push_ready_o = (Depth - count) >= 2, computed from the registered count.
  - Pop in the same cycle does not raise ready.
  - A push is accepted when push_ready_o && push_valid_i[0]. Lane0 is written at wptr, lane1 at wptr+1.
  - wptr advances by the number of accepted lanes.
- Prediction kill: if lane0 is accepted with ptaken = 1, lane1 is dropped (not written, not counted) even when push_valid_i[1] = 1.
- push_valid_i = 10 is illegal:
  - Assertion fires.
  - RTL ignores lane1, so nothing is pushed.
- Pop outputs:
  - pop_valid_o[0] = count >= 1; pop_valid_o[1] = count >= 2.
  - pop_data_o lanes read from rptr and rptr+1.
  - Lanes that are not valid drive NULL_IR_REG.
- Pop: rptr advances by popcount(pop_ack_i & pop_valid_o).
  - pop_ack_i = 10 is illegal: assertion fires; treated as 00.
  - Ack on an invalid lane is masked and raises an assertion.
- Simultaneous push and pop: count_next = count + pushed - popped; never exceeds Depth.
- Latency without bypass: a pushed entry is visible on pop_* the next cycle.
- Flush:
  - flush_i = 1 sets count, rptr and wptr to 0 next cycle.
  - Same-cycle push and ack have no effect.
  - Storage contents are not cleared.
  - pop_valid_o is 00 the cycle after flush.
- Reset mid-operation: immediate asynchronous return to the reset values above.
- Every entry is stored verbatim, including the errs fields; no filtering.

Optional Feature:
- Macro: IR_FIFO_BYPASS_EN.
- With the macro, when count = 0 and flush_i = 0:
  - Accepted push lanes are driven combinationally on pop_valid_o / pop_data_o in the same cycle.
  - The prediction kill applies to the forwarded lanes.
  - Lanes acked in that cycle are not written; unacked lanes are written and count updated.
- Without the macro: strict one-cycle latency and no combinational path from push_* to pop_*.

Decomposition:
- super_pkg keeps ir_reg_t and NULL_IR_REG.
- Add to super_pkg: constant IrFifoDepth = 4, used as the instantiation default.
- No sub-module. Storage is an inline register array with two write ports and two read ports.
- Legality assertions live in the module under a simulation guard.

Test Plan:
- Push 11 with pc 0x100/0x104 into an empty FIFO -> next cycle pop_valid_o = 11, pc 0x100/0x104, count_o = 2.
- Fill to count_o = 3 (Depth 4) -> push_ready_o = 0. A same-cycle pop ack 01 still gives no acceptance; ready returns the following cycle.
- Push 11 with lane0 ptaken = 1, ptarget = 0x200 -> count_o increments by 1 only; lane1 never appears.
- Wrap: five rounds of push 11 / ack 11 -> in-order pc sequence preserved across pointer wrap; count_o stays 2 during steady state.
- Count 3 with push 11, ack 11 and flush_i = 1 in the same cycle -> next cycle count_o = 0, pop_valid_o = 00, push_ready_o = 1.
- IR_FIFO_BYPASS_EN: empty FIFO, push 11, ack 01 in the same cycle -> lane0 consumed immediately; next cycle count_o = 1 with lane1 at the head.
